// File: rtl/agu_ld_sd_queue_if.sv
// ---------------------------------------------------------------------------
// agu_ld_sd_queue_if
// Bundles the request-side and CDB-side signals of the ld/sd address unit.
//   Request side : in_valid/in_ready handshake, RY_data, imediate, reg_dest,
//                  is_store, RS_position, flush
//   CDB side     : cdb_req/cdb_grant handshake, ULA_output packet
//   Status       : err_dest pulse, count (FIFO occupancy)
// The slave modport is taken by the unit, the master modport by whoever
// drives requests and the arbiter grant.
// ---------------------------------------------------------------------------
interface agu_ld_sd_queue_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 4,
  parameter int ADDR_W = 10,
  parameter int NREGS  = 3,
  parameter int RS_W   = 2,
  parameter int DEPTH  = 2
);
  localparam int DEST_W = $clog2(NREGS + 1);
  localparam int PKT_W  = NREGS + RS_W + 1 + ADDR_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] RY_data;
  logic [IMM_W-1:0]  imediate;
  logic [DEST_W-1:0] reg_dest;
  logic              is_store;
  logic [RS_W-1:0]   RS_position;
  logic              flush;
  logic              cdb_req;
  logic              cdb_grant;
  logic [PKT_W-1:0]  ULA_output;
  logic              err_dest;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, RY_data, imediate, reg_dest, is_store, RS_position,
           flush, cdb_grant,
    output in_ready, cdb_req, ULA_output, err_dest, count
  );

  modport master (
    output in_valid, RY_data, imediate, reg_dest, is_store, RS_position,
           flush, cdb_grant,
    input  in_ready, cdb_req, ULA_output, err_dest, count
  );
endinterface

// File: rtl/agu_ld_sd_queue.sv
// ---------------------------------------------------------------------------
// agu_ld_sd_queue
// Load/store address-generation unit for the Tomasulo back end. Computes
// addr = RY_data + ext(imediate), wraps it into a CDB packet
// {dest_onehot, RS_position, UNIT_ID, addr}, queues it in a small FIFO and
// issues it to the CDB through a request/grant handshake.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : agu_ld_sd_queue_if.slave (request, CDB and status signals)
// ---------------------------------------------------------------------------
module agu_ld_sd_queue #(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 4,
  parameter int ADDR_W     = 10,
  parameter int NREGS      = 3,
  parameter int RS_W       = 2,
  parameter int DEPTH      = 2,
  parameter bit IMM_SIGNED = 1'b0,
  parameter bit UNIT_ID    = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  agu_ld_sd_queue_if.slave       bus
);

  localparam int DEST_W = $clog2(NREGS + 1);
  localparam int PKT_W  = NREGS + RS_W + 1 + ADDR_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DEST_W-1:0] NREGS_D  = DEST_W'(NREGS);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------
  // Packet construction
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_addr;
  logic [NREGS-1:0]  w_dest_onehot;
  logic [PKT_W-1:0]  w_pkt;

  generate
    if (IMM_SIGNED) begin : g_imm_sext
      assign w_imm_ext = {{(DATA_W-IMM_W){bus.imediate[IMM_W-1]}}, bus.imediate};
    end else begin : g_imm_zext
      assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.imediate};
    end
  endgenerate

  // Sum is modulo 2^DATA_W and then truncated; both wraps are silent.
  assign w_addr = ADDR_W'(bus.RY_data + w_imm_ext);

  // MSB of the one-hot field is R0, so register r lands on bit NREGS-1-r.
  // Stores never write back, so the field stays zero for them.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_onehot
      assign w_dest_onehot[gi] = !bus.is_store &&
                                 (bus.reg_dest == DEST_W'(NREGS - 1 - gi));
    end
  endgenerate

  assign w_pkt = {w_dest_onehot, bus.RS_position, UNIT_ID, w_addr};

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_err_dest;
  logic [PKT_W-1:0] r_mem [DEPTH];

  logic w_in_ready;
  logic w_accept;
  logic w_dest_bad;
  logic w_push;
  logic w_pop;
  logic w_not_empty;

  // No pass-through when full: readiness depends only on registered count.
  assign w_in_ready  = (r_count < DEPTH_C);
  assign w_not_empty = (r_count != '0);
  assign w_accept    = bus.in_valid && w_in_ready;

  // A load to a non-existent register is consumed but never queued.
  assign w_dest_bad  = !bus.is_store && (bus.reg_dest >= NREGS_D);

  // Flush discards both sides of the FIFO for this edge.
  assign w_push = w_accept && !w_dest_bad && !bus.flush;
  assign w_pop  = w_not_empty && bus.cdb_grant && !bus.flush;

  // ---------------------------------------------------------------------
  // FIFO control state
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err_dest <= 1'b0;
    end else begin
      // Error is reported even when the request is squashed by a flush.
      r_err_dest <= w_accept && w_dest_bad;

      if (bus.flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push) begin
          r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Packet storage carries no reset: entries are only observed while
  // count says they are valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_pkt;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.cdb_req    = w_not_empty;
  assign bus.ULA_output = w_not_empty ? r_mem[r_rd_ptr] : '1;
  assign bus.err_dest   = r_err_dest;
  assign bus.count      = r_count;

endmodule

// File: doc/agu_ld_sd_queue.md
Name: agu_ld_sd_queue

Overview:
- Parametrised load/store address-generation unit for the Tomasulo back end.
- Computes effective address = RY_data + immediate and builds a common-data-bus (CDB) packet. The packet carries the one-hot destination register, the RS position, a unit-ID bit and the address.
- Packets are buffered in a small FIFO and issued to the CDB through a request/grant arbiter handshake.
- Adds over the previous generation: input/output handshakes, queueing, store mode (no register write), signed immediates, flush and dest-error reporting.

Parameters:
- DATA_W, 16: width of RY_data.
- IMM_W, 4: immediate width.
- ADDR_W, 10: address/data field width in the CDB packet.
- NREGS, 3: number of architectural registers; width of the one-hot dest field.
- RS_W, 2: width of the RS position field.
- DEPTH, 2: output FIFO entries, must be ≥1.
- IMM_SIGNED, 0: 1 sign-extends the immediate, 0 zero-extends it.
- UNIT_ID, 0: value of the packet unit bit (0 = ld/sd unit, 1 = main ULA).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands ready, request is presented
- in_ready  out  1  unit can accept the request this cycle
- RY_data  in  DATA_W  base register value
- imediate  in  IMM_W  offset
- reg_dest  in  $clog2(NREGS+1)  binary destination register index
- is_store  in  1  1 = store: no register writeback
- RS_position  in  RS_W  RS slot of the instruction
- flush  in  1  synchronous squash of all queued packets
- cdb_req  out  1  head packet valid, requesting the CDB
- cdb_grant  in  1  arbiter grant for this cycle
- ULA_output  out  NREGS+RS_W+1+ADDR_W  packet {dest_onehot, RS_position, UNIT_ID, addr}
- err_dest  out  1  one-cycle pulse: a load was accepted with reg_dest ≥ NREGS
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FIFO emptied, count=0, cdb_req=0, err_dest=0.
  - ULA_output all ones (invalid marker).
  - Applies immediately, including while a packet is mid-transfer; a granted-but-not-popped head is lost.
- Address arithmetic:
  - imm_ext = sign- or zero-extension of imediate to DATA_W, per IMM_SIGNED.
  - sum = RY_data + imm_ext, modulo 2^DATA_W.
  - addr = sum[ADDR_W-1:0]; truncation and wrap are silent.
- Dest encoding:
  - Load: dest_onehot bit (NREGS-1-reg_dest) set. MSB = R0, matching the existing CDB format.
  - Store: dest_onehot = 0; reg_dest is ignored.
  - Load with reg_dest ≥ NREGS: the packet is not pushed, but the request is still consumed (in_ready handshake completes) and err_dest pulses on the next cycle.
- Input handshake:
  - in_ready = (count < DEPTH), combinational from registered count. No pass-through when full, even if a pop occurs that cycle.
  - Accept when in_valid && in_ready at a rising edge; the packet is written to the FIFO tail at that edge.
- Output:
  - cdb_req = (count ≠ 0).
  - ULA_output = head packet when count ≠ 0, otherwise all ones.
  - Pop at a rising edge when cdb_req && cdb_grant. A grant while empty is ignored.
  - Latency: accepted at edge N → cdb_req and ULA_output valid after edge N (one-cycle latency, minimum).
  - Packets issue in strict FIFO order.
  - Head is held stable while cdb_req=1 and no grant arrives.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, head advances, tail advances.
  - flush=1: count := 0 at the edge; any push or pop that cycle is discarded; err_dest is still reported for the squashed request.
- FIFO pointers: wrap modulo DEPTH; count is never above DEPTH or below 0.

Test Plan:
- Basic load:
  - Stimulus: defaults, RY=16'h0010, imm=4'h3, dest=1, RS=1, grant held 1.
  - Required response: after one edge cdb_req=1, ULA_output=16'b010_01_0_0000010011; next edge popped, ULA_output=16'hFFFF.
- Store and signed immediate:
  - Stimulus: IMM_SIGNED=1, store, RY=16'h0005, imm=4'hF, RS=2.
  - Required response: ULA_output=16'b000_10_0_0000000100.
- Backpressure:
  - Stimulus: DEPTH=2, grant=0, three back-to-back loads.
  - Required response: the first two are accepted and count=2; in_ready=0 on the third until grant; issue order is preserved.
- Simultaneous push and pop:
  - Stimulus: count=1, grant=1 with a new valid request.
  - Required response: count stays 1, the new packet is at head the next cycle.
- Wrap, error and flush:
  - Stimulus: RY=16'hFFFF, imm=1 → addr=0; then dest=3 with NREGS=3.
  - Required response: no push, err_dest pulses 1 cycle.
  - Stimulus: flush with count=2.
  - Required response: count=0, ULA_output=16'hFFFF.
- Async reset:
  - Stimulus: reset_n low mid-cycle with count=2.
  - Required response: outputs reset without waiting for a clock edge, and in_ready=1 once reset is released.
